// File: rtl/uart_rx_fifo_if.sv
// Host-side read port of the UART receiver: show-ahead byte, valid/ready pop and FIFO occupancy.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 4
) ();
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [$clog2(DEPTH):0] fill;

  modport master (output rx_data, rx_valid, fill, input rx_ready);
  modport slave  (input rx_data, rx_valid, fill, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Good bytes go into a show-ahead FIFO. Framing errors and overruns are reported as one-cycle pulses.
module uart_rx_fifo #(
  parameter int clk_value = 100_000_000,
  parameter int baud      = 9600,
  parameter int DEPTH     = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_i,
  uart_rx_fifo_if.master host,
  output logic           frame_err_o,
  output logic           overrun_o
);
  localparam int os_div = clk_value / (baud * 16);
  localparam int OsW    = (os_div > 1) ? $clog2(os_div) : 1;
  localparam int PtrW   = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q, state_d;
  logic           sync1_q, rxs_q;
  logic [OsW-1:0] osCnt_q, osCnt_d;
  logic [3:0]     sCnt_q, sCnt_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [1:0]     smp_q, smp_d;
  logic [7:0]     shift_q, shift_d;
  logic           armed_q, armed_d;
  logic           frameErr_q, frameErr_d;
  logic           overrun_q, overrun_d;
  logic           tick, vote, push, pop, accept, notEmpty;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q, rdPtr_q;
  logic [PtrW:0]   fill_q, fill_d;

  assign tick = (state_q != IDLE) && (osCnt_q == OsW'(os_div - 1));
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

  // After a framing error the line must be seen high once before a new start is armed.
  always_comb begin
    state_d    = state_q;
    osCnt_d    = osCnt_q;
    sCnt_d     = sCnt_q;
    bitIdx_d   = bitIdx_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    push       = 1'b0;
    frameErr_d = 1'b0;

    if (state_q == IDLE) begin
      osCnt_d  = '0;
      sCnt_d   = '0;
      bitIdx_d = '0;
    end else begin
      osCnt_d = tick ? '0 : osCnt_q + 1'b1;
      if (tick) sCnt_d = sCnt_q + 1'b1;
      if (tick && sCnt_q == 4'd7) smp_d[0] = rxs_q;
      if (tick && sCnt_q == 4'd8) smp_d[1] = rxs_q;
    end

    unique case (state_q)
      IDLE: begin
        armed_d = armed_q | rxs_q;
        if (armed_q && !rxs_q) state_d = START;
      end
      START: begin
        if (tick && sCnt_q == 4'd9 && vote) state_d = IDLE;
        else if (tick && sCnt_q == 4'd15) state_d = DATA;
      end
      DATA: begin
        if (tick && sCnt_q == 4'd9) shift_d = {vote, shift_q[7:1]};
        if (tick && sCnt_q == 4'd15) begin
          if (bitIdx_q == 3'd7) state_d = STOP;
          else bitIdx_d = bitIdx_q + 1'b1;
        end
      end
      STOP: begin
        if (tick && sCnt_q == 4'd9) begin
          if (vote) begin
            push = 1'b1;
          end else begin
            frameErr_d = 1'b1;
            armed_d    = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still takes a byte when the host pops in the same cycle.
  always_comb begin
    notEmpty  = (fill_q != '0);
    pop       = notEmpty && host.rx_ready;
    accept    = push && ((fill_q < (PtrW+1)'(DEPTH)) || pop);
    overrun_d = push && !accept;
    unique case ({accept, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= IDLE;
      osCnt_q    <= '0;
      sCnt_q     <= '0;
      bitIdx_q   <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b1;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      fill_q     <= '0;
    end else begin
      sync1_q    <= rx_i;
      rxs_q      <= sync1_q;
      state_q    <= state_d;
      osCnt_q    <= osCnt_d;
      sCnt_q     <= sCnt_d;
      bitIdx_q   <= bitIdx_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
      fill_q     <= fill_d;
      if (accept) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wrPtr_q] <= shift_q;
  end

  assign host.rx_valid = notEmpty;
  assign host.rx_data  = notEmpty ? mem_q[rdPtr_q] : 8'h00;
  assign host.fill     = fill_q;
  assign frame_err_o   = frameErr_q;
  assign overrun_o     = overrun_q;
endmodule
